// File: rtl/rs_alu_bank.sv
// Reservation-station bank feeding a LAT-stage integer ALU pipeline.
// Entries wake up from the CDB; the oldest ready entry issues, results leave under backpressure.
module rs_alu_bank #(
  parameter int ENTRIES  = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int BASE_TAG = 1,
  parameter int LAT      = 2
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET,
  input  logic                           flush,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [3:0]                     issue_op,
  input  logic [TAG_W-1:0]               issue_tag1,
  input  logic [TAG_W-1:0]               issue_tag2,
  input  logic [DATA_W-1:0]              issue_val1,
  input  logic [DATA_W-1:0]              issue_val2,
  output logic [TAG_W-1:0]               issue_dest_tag,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [TAG_W-1:0]               res_tag,
  output logic [DATA_W-1:0]              res_data,
  output logic [$clog2(ENTRIES+1)-1:0]   busy_count
);
  localparam int IW = $clog2(ENTRIES);
  localparam int AW = IW + 1;
  localparam int CW = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] busy_q, busy_d, exec_q, exec_d, ready;
  logic [3:0]         op_q   [ENTRIES];
  logic [3:0]         op_d   [ENTRIES];
  logic [TAG_W-1:0]   tag1_q [ENTRIES];
  logic [TAG_W-1:0]   tag1_d [ENTRIES];
  logic [TAG_W-1:0]   tag2_q [ENTRIES];
  logic [TAG_W-1:0]   tag2_d [ENTRIES];
  logic [DATA_W-1:0]  val1_q [ENTRIES];
  logic [DATA_W-1:0]  val1_d [ENTRIES];
  logic [DATA_W-1:0]  val2_q [ENTRIES];
  logic [DATA_W-1:0]  val2_d [ENTRIES];
  logic [AW-1:0]      age_q  [ENTRIES];
  logic [AW-1:0]      age_d  [ENTRIES];
  logic [AW-1:0]      age_ctr_q, age_ctr_d;

  logic [LAT-1:0]     st_v_q, st_v_d, adv;
  logic [TAG_W-1:0]   st_tag_q  [LAT];
  logic [TAG_W-1:0]   st_tag_d  [LAT];
  logic [DATA_W-1:0]  st_data_q [LAT];
  logic [DATA_W-1:0]  st_data_d [LAT];

  logic [IW-1:0]      free_idx, sel_idx;
  logic               free_found, sel_found, do_issue, dispatch, res_fire, acc;
  logic [AW-1:0]      sel_age, age_diff;
  logic [CW-1:0]      count;

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      4'b0000: alu = a + b;
      4'b1000: alu = a - b;
      4'b0010: alu = DATA_W'($signed(a) < $signed(b));
      4'b0011: alu = DATA_W'(a < b);
      4'b0100: alu = a ^ b;
      4'b0110: alu = a | b;
      4'b0111: alu = a & b;
      default: alu = '0;
    endcase
  endfunction

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ready
    assign ready[gi] = busy_q[gi] && !exec_q[gi] && (tag1_q[gi] == '0) && (tag2_q[gi] == '0);
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  assign issue_ready    = free_found;
  assign issue_dest_tag = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
  assign do_issue       = issue_valid && issue_ready;

  // Age stamps wrap; a is older than b when (a - b) is negative modulo 2^AW.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    age_diff  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      age_diff = age_q[i] - sel_age;
      if (ready[i] && (!sel_found || age_diff[AW-1])) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_age   = age_q[i];
      end
    end
  end

  // A stage can take new contents if it or any later stage has a hole, or the output drains.
  always_comb begin
    acc = res_ready;
    adv = '0;
    for (int s = LAT - 1; s >= 0; s--) begin
      acc    = acc | ~st_v_q[s];
      adv[s] = acc;
    end
  end

  assign dispatch = adv[0] && sel_found;
  assign res_fire = st_v_q[LAT-1] && res_ready;

  always_comb begin
    st_v_d = st_v_q;
    for (int s = 0; s < LAT; s++) begin
      st_tag_d[s]  = st_tag_q[s];
      st_data_d[s] = st_data_q[s];
    end
    if (adv[0]) begin
      st_v_d[0]    = dispatch;
      st_tag_d[0]  = dispatch ? TAG_W'(BASE_TAG) + TAG_W'(sel_idx) : '0;
      st_data_d[0] = dispatch ? alu(op_q[sel_idx], val1_q[sel_idx], val2_q[sel_idx]) : '0;
    end
    for (int s = 1; s < LAT; s++) begin
      if (adv[s]) begin
        st_v_d[s]    = st_v_q[s-1];
        st_tag_d[s]  = st_tag_q[s-1];
        st_data_d[s] = st_data_q[s-1];
      end
    end
  end

  always_comb begin
    busy_d    = busy_q;
    exec_d    = exec_q;
    age_ctr_d = age_ctr_q + AW'(do_issue);
    for (int i = 0; i < ENTRIES; i++) begin
      op_d[i]   = op_q[i];
      tag1_d[i] = tag1_q[i];
      tag2_d[i] = tag2_q[i];
      val1_d[i] = val1_q[i];
      val2_d[i] = val2_q[i];
      age_d[i]  = age_q[i];
      if (busy_q[i] && !exec_q[i] && cdb_valid) begin
        if (tag1_q[i] != '0 && cdb_tag == tag1_q[i]) begin
          tag1_d[i] = '0;
          val1_d[i] = cdb_data;
        end
        if (tag2_q[i] != '0 && cdb_tag == tag2_q[i]) begin
          tag2_d[i] = '0;
          val2_d[i] = cdb_data;
        end
      end
      if (dispatch && sel_idx == IW'(i)) exec_d[i] = 1'b1;
      if (res_fire && st_tag_q[LAT-1] == TAG_W'(BASE_TAG + i)) begin
        busy_d[i] = 1'b0;
        exec_d[i] = 1'b0;
      end
      if (do_issue && free_idx == IW'(i)) begin
        busy_d[i] = 1'b1;
        exec_d[i] = 1'b0;
        op_d[i]   = issue_op;
        age_d[i]  = age_ctr_q;
        if (issue_tag1 == '0) begin
          tag1_d[i] = '0;
          val1_d[i] = issue_val1;
        end else if (cdb_valid && cdb_tag == issue_tag1) begin
          tag1_d[i] = '0;
          val1_d[i] = cdb_data;
        end else begin
          tag1_d[i] = issue_tag1;
          val1_d[i] = '0;
        end
        if (issue_tag2 == '0) begin
          tag2_d[i] = '0;
          val2_d[i] = issue_val2;
        end else if (cdb_valid && cdb_tag == issue_tag2) begin
          tag2_d[i] = '0;
          val2_d[i] = cdb_data;
        end else begin
          tag2_d[i] = issue_tag2;
          val2_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < ENTRIES; i++) count = count + CW'(busy_q[i]);
  end

  assign busy_count = count;
  assign res_valid  = st_v_q[LAT-1];
  assign res_tag    = st_tag_q[LAT-1];
  assign res_data   = st_data_q[LAT-1];

  always_ff @(posedge CLOCK_50) begin
    if (RESET || flush) begin
      busy_q    <= '0;
      exec_q    <= '0;
      age_ctr_q <= '0;
      st_v_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        age_q[i]  <= '0;
      end
      for (int s = 0; s < LAT; s++) begin
        st_tag_q[s]  <= '0;
        st_data_q[s] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      exec_q    <= exec_d;
      age_ctr_q <= age_ctr_d;
      st_v_q    <= st_v_d;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= op_d[i];
        tag1_q[i] <= tag1_d[i];
        tag2_q[i] <= tag2_d[i];
        val1_q[i] <= val1_d[i];
        val2_q[i] <= val2_d[i];
        age_q[i]  <= age_d[i];
      end
      for (int s = 0; s < LAT; s++) begin
        st_tag_q[s]  <= st_tag_d[s];
        st_data_q[s] <= st_data_d[s];
      end
    end
  end
endmodule

// File: tb/tb_rs_alu_bank.sv
// Directed and randomized checks of rs_alu_bank against an in-bench transaction model.
module tb_rs_alu_bank;
  localparam int ENTRIES  = 4;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int BASE_TAG = 1;
  localparam int LAT      = 2;

  logic              CLOCK_50 = 1'b0;
  logic              RESET = 1'b1, flush = 1'b0;
  logic              issue_valid = 1'b0, issue_ready;
  logic [3:0]        issue_op = '0;
  logic [TAG_W-1:0]  issue_tag1 = '0, issue_tag2 = '0, issue_dest_tag;
  logic [DATA_W-1:0] issue_val1 = '0, issue_val2 = '0;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic              res_valid, res_ready = 1'b1;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic [2:0]        busy_count;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  rs_alu_bank #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W),
                .BASE_TAG(BASE_TAG), .LAT(LAT)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
    .issue_val1(issue_val1), .issue_val2(issue_val2), .issue_dest_tag(issue_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
    .busy_count(busy_count)
  );

  function automatic logic [DATA_W-1:0] ref_alu(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd8:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd3:    return (a < b) ? 1 : 0;
      4'd4:    return a ^ b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] op, input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                          input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    issue_valid = 1'b1;
    issue_op = op; issue_tag1 = t1; issue_tag2 = t2; issue_val1 = v1; issue_val2 = v2;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic cdb_pulse(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Waits for a result, checks it, then lets it handshake (res_ready must be 1).
  task automatic collect(input string name, input logic [TAG_W-1:0] et, input logic [DATA_W-1:0] ed,
                         output int n);
    wait_res(n);
    chk({name, "_valid"}, res_valid, 1'b1);
    chk({name, "_tag"}, res_tag, et);
    chk({name, "_data"}, res_data, ed);
    tick();
  endtask

  logic [3:0]        ops [10] = '{4'd0, 4'd8, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd1, 4'd5, 4'd15};
  bit                m_busy [ENTRIES];
  logic [TAG_W-1:0]  q_tag [$];
  logic [DATA_W-1:0] q_data [$];

  initial begin
    int n;
    int m_cnt, m_free;
    bit iv, rr;
    logic [3:0] op;
    logic [DATA_W-1:0] a, b;
    logic [TAG_W-1:0] ht;

    // Reset state
    tick(); tick();
    RESET = 1'b0;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy_count, 0);
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_dest_tag", issue_dest_tag, BASE_TAG);

    // ADD with both operands present: exact latency
    do_issue(4'b0000, 0, 0, 5, 7);
    chk("add_busy", busy_count, 1);
    collect("add", 1, 12, n);
    chk("add_latency", n, LAT);
    chk("add_busy_after", busy_count, 0);

    // SUB waiting on tag 9, broadcast two cycles after issue
    do_issue(4'b1000, 9, 0, 0, 3);
    tick();
    chk("sub_wait_res_valid", res_valid, 1'b0);
    chk("sub_wait_busy", busy_count, 1);
    cdb_pulse(9, 10);
    collect("sub_wait", 1, 7, n);
    chk("sub_wait_latency", n, LAT);

    // Same with the broadcast in the issue cycle (bypass)
    cdb_valid = 1'b1; cdb_tag = 9; cdb_data = 10;
    do_issue(4'b1000, 9, 0, 0, 3);
    cdb_valid = 1'b0;
    collect("sub_bypass", 1, 7, n);
    chk("sub_bypass_latency", n, LAT);

    // Fill every entry behind tag 9; a fifth issue is ignored
    for (int i = 0; i < ENTRIES; i++) begin
      chk("fill_dest_tag", issue_dest_tag, BASE_TAG + i);
      do_issue(4'b0000, 9, 0, 0, DATA_W'(i));
    end
    chk("full_issue_ready", issue_ready, 1'b0);
    chk("full_busy", busy_count, ENTRIES);
    do_issue(4'b0000, 0, 0, 1, 1);
    chk("full_ignored_busy", busy_count, ENTRIES);
    chk("full_no_result", res_valid, 1'b0);
    cdb_pulse(9, 100);
    for (int i = 0; i < ENTRIES; i++) collect("full_drain", TAG_W'(BASE_TAG + i), 100 + DATA_W'(i), n);
    chk("full_drain_busy", busy_count, 0);
    chk("full_drain_res_valid", res_valid, 1'b0);

    // Comparisons and logic
    do_issue(4'b0010, 0, 0, 32'hFFFF_FFFF, 1);
    collect("slt", 1, 1, n);
    do_issue(4'b0011, 0, 0, 32'hFFFF_FFFF, 1);
    collect("sltu", 1, 0, n);
    do_issue(4'b0111, 0, 0, 32'h0000_F0F0, 32'h0000_0FF0);
    collect("and", 1, 32'h0000_00F0, n);

    // Backpressure with three results in flight
    res_ready = 1'b0;
    do_issue(4'b0000, 0, 0, 1, 10);
    do_issue(4'b0000, 0, 0, 2, 20);
    do_issue(4'b0000, 0, 0, 3, 30);
    wait_res(n);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", res_valid, 1'b1);
      chk("stall_tag", res_tag, 1);
      chk("stall_data", res_data, 11);
      tick();
    end
    chk("stall_busy", busy_count, 3);
    res_ready = 1'b1;
    collect("release0", 1, 11, n);
    collect("release1", 2, 22, n);
    chk("release1_back_to_back", n, 0);
    collect("release2", 3, 33, n);
    chk("release2_back_to_back", n, 0);

    // Flush, then reset, with three busy entries and a result waiting
    for (int pass = 0; pass < 2; pass++) begin
      res_ready = 1'b0;
      do_issue(4'b0100, 0, 0, 1, 3);
      do_issue(4'b0110, 0, 0, 1, 3);
      do_issue(4'b0000, 9, 0, 1, 3);
      wait_res(n);
      chk("squash_pre_valid", res_valid, 1'b1);
      chk("squash_pre_busy", busy_count, 3);
      if (pass == 0) flush = 1'b1; else RESET = 1'b1;
      tick();
      flush = 1'b0; RESET = 1'b0;
      res_ready = 1'b1;
      chk("squash_res_valid", res_valid, 1'b0);
      chk("squash_busy", busy_count, 0);
      chk("squash_dest_tag", issue_dest_tag, BASE_TAG);
      chk("squash_issue_ready", issue_ready, 1'b1);
    end

    // Randomized traffic against the transaction model
    for (int i = 0; i < ENTRIES; i++) m_busy[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      m_cnt = 0; m_free = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (m_busy[i]) m_cnt++;
        else m_free = i;
      end
      chk("rnd_busy", busy_count, m_cnt);
      chk("rnd_issue_ready", issue_ready, m_cnt < ENTRIES);
      if (m_cnt < ENTRIES) chk("rnd_dest_tag", issue_dest_tag, BASE_TAG + m_free);
      iv = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 3) != 0);
      op = ops[$urandom_range(0, 9)];
      a = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 3)) - 1 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 3)) - 1 : $urandom;
      issue_valid = iv; issue_op = op; issue_tag1 = 0; issue_tag2 = 0;
      issue_val1 = a; issue_val2 = b; res_ready = rr;
      if (res_valid && rr) begin
        if (q_tag.size() == 0) begin
          chk("rnd_unexpected_result", res_valid, 1'b0);
        end else begin
          chk("rnd_tag", res_tag, q_tag[0]);
          chk("rnd_data", res_data, q_data[0]);
          ht = q_tag.pop_front();
          void'(q_data.pop_front());
          m_busy[int'(ht) - BASE_TAG] = 1'b0;
        end
      end
      if (iv && m_cnt < ENTRIES) begin
        q_tag.push_back(TAG_W'(BASE_TAG + m_free));
        q_data.push_back(ref_alu(op, a, b));
        m_busy[m_free] = 1'b1;
      end
      tick();
    end
    issue_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 40 && q_tag.size() > 0; c++) begin
      if (res_valid) begin
        chk("drain_tag", res_tag, q_tag[0]);
        chk("drain_data", res_data, q_data[0]);
        void'(q_tag.pop_front());
        void'(q_data.pop_front());
      end
      tick();
    end
    chk("drain_queue_empty", q_tag.size(), 0);
    chk("drain_busy", busy_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
